// File: rtl/fccc_ngmux_switch_ctrl.sv
// fccc_ngmux_switch_ctrl
//   Sequencer for the NGMUX glitchless clock muxes of an FCCC instance.
//   Runs on a free-running reference clock and drives the NGMUXn_SEL,
//   NGMUXn_HOLD_N and NGMUXn_ARST_N pins directly. A filtered PLL lock
//   gates every request for the PLL source. Channels are switched one at a
//   time with a hold / select / settle sequence, and any channel left on the
//   PLL after lock loss falls back to the bypass source.
//
// Ports
//   CLK           reference clock, rising edge
//   RESET         asynchronous active-high reset
//   PLL_LOCK      raw FCCC LOCK, asynchronous to CLK
//   SEL_REQ       requested source per channel (0 = bypass, 1 = PLL), level
//   NGMUX_SEL     per-channel mux select
//   NGMUX_HOLD_N  per-channel mux hold, active low
//   NGMUX_ARST_N  per-channel mux reset, active low
//   LOCK_OK       filtered lock status
//   BUSY          high whenever the sequencer is not idle
//   DONE          one-cycle pulse at the end of each switch sequence
//   ACTIVE_CH     channel currently (or most recently) being switched
module fccc_ngmux_switch_ctrl #(
  parameter int NUM_CH     = 2,
  parameter int HOLD_CYC   = 4,
  parameter int SETTLE_CYC = 16,
  parameter int LOCK_FILT  = 8,
  parameter int INIT_CYC   = 8,
  parameter int CNT_W      = 8,
  localparam int AW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PLL_LOCK,
  input  logic [NUM_CH-1:0] SEL_REQ,
  output logic [NUM_CH-1:0] NGMUX_SEL,
  output logic [NUM_CH-1:0] NGMUX_HOLD_N,
  output logic [NUM_CH-1:0] NGMUX_ARST_N,
  output logic              LOCK_OK,
  output logic              BUSY,
  output logic              DONE,
  output logic [AW-1:0]     ACTIVE_CH
);

  localparam logic [CNT_W-1:0] LOCK_LIM   = CNT_W'(LOCK_FILT);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETL_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_HOLD,
    S_SWITCH,
    S_RELEASE
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

  logic              lock_s1;
  logic              lock_s2;
  logic [CNT_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  lock_cnt_nxt;

  state_t            state;
  logic [CNT_W-1:0]  seq_cnt;
  logic              dir;

  logic [NUM_CH-1:0] tgt;
  logic [NUM_CH-1:0] pend;
  logic [AW-1:0]     pend_idx;

  // Lock synchroniser and filter. LOCK_OK sets on the same edge the counter
  // reaches the limit, so it rises LOCK_FILT+2 edges after PLL_LOCK and
  // drops one edge after the synchronised low arrives.
  assign lock_cnt_nxt = sat_inc(lock_cnt, LOCK_LIM);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_s1  <= 1'b0;
      lock_s2  <= 1'b0;
      lock_cnt <= '0;
      LOCK_OK  <= 1'b0;
    end else begin
      lock_s1 <= PLL_LOCK;
      lock_s2 <= lock_s1;
      if (!lock_s2) begin
        lock_cnt <= '0;
        LOCK_OK  <= 1'b0;
      end else begin
        lock_cnt <= lock_cnt_nxt;
        LOCK_OK  <= (lock_cnt_nxt == LOCK_LIM);
      end
    end
  end

  // Pending detection: a PLL request only counts while lock is good, so
  // losing lock turns every channel on the PLL into a pending fallback.
  assign tgt  = SEL_REQ & {NUM_CH{LOCK_OK}};
  assign pend = tgt ^ NGMUX_SEL;

  always_comb begin
    pend_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) pend_idx = AW'(i);
    end
  end

  // Switch sequencer. All pin outputs are registered and change only on
  // state transitions, so each pin moves on exactly one edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= S_INIT;
      seq_cnt      <= '0;
      dir          <= 1'b0;
      NGMUX_SEL    <= '0;
      NGMUX_HOLD_N <= '1;
      NGMUX_ARST_N <= '0;
      BUSY         <= 1'b1;
      DONE         <= 1'b0;
      ACTIVE_CH    <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_INIT: begin
          if (seq_cnt == INIT_LAST) begin
            seq_cnt      <= '0;
            NGMUX_ARST_N <= '1;
            BUSY         <= 1'b0;
            state        <= S_IDLE;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end

        S_IDLE: begin
          if (|pend) begin
            ACTIVE_CH              <= pend_idx;
            dir                    <= tgt[pend_idx];
            NGMUX_HOLD_N[pend_idx] <= 1'b0;
            BUSY                   <= 1'b1;
            seq_cnt                <= '0;
            state                  <= S_HOLD;
          end
        end

        S_HOLD: begin
          // A switch towards the PLL is abandoned if lock goes away before
          // SEL has moved; the mux is released on its old source.
          if (dir && !LOCK_OK) begin
            NGMUX_HOLD_N[ACTIVE_CH] <= 1'b1;
            DONE                    <= 1'b1;
            seq_cnt                 <= '0;
            state                   <= S_RELEASE;
          end else if (seq_cnt == HOLD_LAST) begin
            NGMUX_SEL[ACTIVE_CH] <= dir;
            seq_cnt              <= '0;
            state                <= S_SWITCH;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end

        S_SWITCH: begin
          if (seq_cnt == SETL_LAST) begin
            NGMUX_HOLD_N[ACTIVE_CH] <= 1'b1;
            DONE                    <= 1'b1;
            seq_cnt                 <= '0;
            state                   <= S_RELEASE;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end

        S_RELEASE: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          BUSY    <= 1'b0;
          seq_cnt <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
